// File: rtl/branch_predict_resolve.sv
// Branch predictor with resolution: a PHT of saturating counters indexed by
// word-aligned PC, and a multi-cycle flush hold after each mispredict.
// The hold window drops any resolving branch and also freezes the
// branch / mispredict statistics.
module branch_predict_resolve #(
  parameter int PC_W      = 32,
  parameter int IDX_W     = 4,
  parameter int CNT_W     = 2,
  parameter int FLUSH_CYC = 1,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   if_pc,
  output logic              predict_pcsrc,
  input  logic              branch,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              actual_pcsrc,
  input  logic              ex_predict_pcsrc,
  output logic              flush,
  output logic              update,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispredict_cnt
);

  localparam int                DEPTH     = 1 << IDX_W;
  localparam logic [3:0]        HOLD_LOAD = 4'(FLUSH_CYC - 1);
  localparam logic [STAT_W-1:0] STAT_MAX  = '1;

  logic [IDX_W-1:0]            if_idx, ex_idx;
  logic [DEPTH-1:0][CNT_W-1:0] pht_cnt;
  logic [DEPTH-1:0]            pht_we;
  logic                        accept, mispredict;
  logic [3:0]                  hold_q, hold_d;
  logic [STAT_W-1:0]           branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0]           mispredict_cnt_q, mispredict_cnt_d;

  // Byte offset and upper PC bits do not take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                            ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // One counter per PHT entry; only the entry hit by an accepted branch moves.
  generate
    for (genvar e = 0; e < DEPTH; e++) begin : g_pht
      assign pht_we[e] = accept && (ex_idx == IDX_W'(e));
      bpr_pht_entry #(.CNT_W(CNT_W)) u_entry (
        .clk   (clk),
        .rst   (rst),
        .we    (pht_we[e]),
        .taken (actual_pcsrc),
        .cnt   (pht_cnt[e])
      );
    end
  endgenerate

  // Prediction reads the registered counter, so a same-cycle write is not seen.
  assign predict_pcsrc = pht_cnt[if_idx][CNT_W-1];

  // Acceptance, flush/update strobes, hold countdown and saturating statistics.
  always_comb begin
    accept           = branch && (hold_q == 4'd0);
    mispredict       = accept && (actual_pcsrc ^ ex_predict_pcsrc);
    update           = accept;
    flush            = mispredict || (hold_q != 4'd0);
    hold_d           = hold_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (mispredict)
      hold_d = HOLD_LOAD;
    else if (hold_q != 4'd0)
      hold_d = hold_q - 4'd1;
    if (accept && branch_cnt_q != STAT_MAX)
      branch_cnt_d = branch_cnt_q + 1'b1;
    if (mispredict && mispredict_cnt_q != STAT_MAX)
      mispredict_cnt_d = mispredict_cnt_q + 1'b1;
  end

  // Control state register; reset wins over a same-cycle resolution.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q           <= 4'd0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      hold_q           <= hold_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// Single PHT entry: CNT_W-bit up/down counter saturating at both ends,
// reset to weakly not-taken (MSB clear, all lower bits set).
module bpr_pht_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             taken,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_MAX >> 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating step toward the resolved direction.
  always_comb begin
    cnt_d = cnt_q;
    if (we) begin
      if (taken && cnt_q != CNT_MAX)
        cnt_d = cnt_q + 1'b1;
      else if (!taken && cnt_q != '0)
        cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= CNT_INIT;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench for branch_predict_resolve: two instances share one stimulus stream.
// Instance a uses default parameters; instance b has FLUSH_CYC=3, STAT_W=2.
// A per-instance integer model tracks counters, flush window and statistics.
module tb_branch_predict_resolve;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0, ex_pc = '0;
  logic        branch = 1'b0, act = 1'b0, pr = 1'b0;

  logic        pred_a, flush_a, upd_a;
  logic [15:0] bc_a, mc_a;
  logic        pred_b, flush_b, upd_b;
  logic [1:0]  bc_b, mc_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: counter values 0..3, remaining extra flush cycles, stats.
  int m_pht  [2][16];
  int m_hold [2];
  int m_bc   [2];
  int m_mc   [2];

  always #5 clk = ~clk;

  branch_predict_resolve dut_a (
    .clk(clk), .rst(rst), .if_pc(if_pc), .predict_pcsrc(pred_a),
    .branch(branch), .ex_pc(ex_pc), .actual_pcsrc(act), .ex_predict_pcsrc(pr),
    .flush(flush_a), .update(upd_a), .branch_cnt(bc_a), .mispredict_cnt(mc_a)
  );

  branch_predict_resolve #(.FLUSH_CYC(3), .STAT_W(2)) dut_b (
    .clk(clk), .rst(rst), .if_pc(if_pc), .predict_pcsrc(pred_b),
    .branch(branch), .ex_pc(ex_pc), .actual_pcsrc(act), .ex_predict_pcsrc(pr),
    .flush(flush_b), .update(upd_b), .branch_cnt(bc_b), .mispredict_cnt(mc_b)
  );

  function automatic int flush_len(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int stat_max(input int i);
    return (i == 0) ? 65535 : 3;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic logic m_accept(input int i);
    return branch && (m_hold[i] == 0);
  endfunction

  function automatic logic m_pred(input int i);
    return m_pht[i][idx_of(if_pc)] >= 2;
  endfunction

  function automatic logic m_flush(input int i);
    return (m_hold[i] > 0) || (m_accept(i) && (act != pr));
  endfunction

  // Advance the model with the current inputs, then clock the DUTs.
  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int k = 0; k < 16; k++) m_pht[i][k] = 1;
        m_hold[i] = 0; m_bc[i] = 0; m_mc[i] = 0;
      end else if (m_accept(i)) begin
        int k;
        k = idx_of(ex_pc);
        m_pht[i][k] = act ? ((m_pht[i][k] < 3) ? m_pht[i][k] + 1 : 3)
                          : ((m_pht[i][k] > 0) ? m_pht[i][k] - 1 : 0);
        if (m_bc[i] < stat_max(i)) m_bc[i]++;
        if (act != pr) begin
          if (m_mc[i] < stat_max(i)) m_mc[i]++;
          m_hold[i] = flush_len(i) - 1;
        end
      end else if (m_hold[i] > 0) begin
        m_hold[i]--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic b, input logic [31:0] ip,
                       input logic [31:0] ep, input logic a, input logic p);
    rst = r; branch = b; if_pc = ip; ex_pc = ep; act = a; pr = p;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0); tick(); tick();
    drive(0, 0, 32'h40, 0, 0, 0);
    n_checks++; if (pred_a !== 1'b0) $display("FAIL reset_pred_a: got %b want 0", pred_a); else n_pass++;
    n_checks++; if (pred_b !== 1'b0) $display("FAIL reset_pred_b: got %b want 0", pred_b); else n_pass++;
    n_checks++; if (bc_a !== 16'd0) $display("FAIL reset_bcnt: got %0d want 0", bc_a); else n_pass++;
    n_checks++; if (mc_a !== 16'd0) $display("FAIL reset_mcnt: got %0d want 0", mc_a); else n_pass++;
    n_checks++; if ({flush_a, upd_a} !== 2'b00) $display("FAIL reset_idle: flush/update got %b want 00", {flush_a, upd_a}); else n_pass++;
  endtask

  task automatic test_training();
    drive(0, 1, 32'h40, 32'h40, 1, 0);
    n_checks++; if ({pred_a, flush_a, upd_a} !== 3'b011) $display("FAIL train_first: pred/flush/update got %b want 011", {pred_a, flush_a, upd_a}); else n_pass++;
    tick();
    drive(0, 1, 32'h40, 32'h40, 1, 1);
    n_checks++; if ({pred_a, flush_a, upd_a} !== 3'b101) $display("FAIL train_second: pred/flush/update got %b want 101", {pred_a, flush_a, upd_a}); else n_pass++;
    tick();
    drive(0, 0, 32'h40, 0, 0, 0);
    n_checks++; if (pred_a !== 1'b1) $display("FAIL train_pred: got %b want 1", pred_a); else n_pass++;
    n_checks++; if (bc_a !== 16'd2) $display("FAIL train_bcnt: got %0d want 2", bc_a); else n_pass++;
    n_checks++; if (mc_a !== 16'd1) $display("FAIL train_mcnt: got %0d want 1", mc_a); else n_pass++;
  endtask

  task automatic test_saturation();
    drive(1, 0, 0, 0, 0, 0); tick();
    for (int n = 0; n < 5; n++) begin drive(0, 1, 32'h44, 32'h44, 1, 1); tick(); end
    drive(0, 0, 32'h44, 0, 0, 0);
    n_checks++; if (pred_a !== 1'b1) $display("FAIL sat_hi_pred: got %b want 1", pred_a); else n_pass++;
    drive(0, 1, 32'h44, 32'h44, 0, 1); tick();
    drive(0, 0, 32'h44, 0, 0, 0);
    n_checks++; if (pred_a !== 1'b1) $display("FAIL sat_hi_nowrap: got %b want 1", pred_a); else n_pass++;
    for (int n = 0; n < 4; n++) begin drive(0, 1, 32'h44, 32'h44, 0, 0); tick(); end
    drive(0, 0, 32'h44, 0, 0, 0);
    n_checks++; if (pred_a !== 1'b0) $display("FAIL sat_lo_pred: got %b want 0", pred_a); else n_pass++;
    drive(0, 1, 32'h44, 32'h44, 1, 0); tick();
    drive(0, 0, 32'h44, 0, 0, 0);
    n_checks++; if (pred_a !== 1'b0) $display("FAIL sat_lo_nowrap: got %b want 0", pred_a); else n_pass++;
  endtask

  task automatic test_flush_hold();
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 32'h48, 32'h48, 1, 0);
    n_checks++; if ({flush_b, upd_b} !== 2'b11) $display("FAIL hold_t: flush/update got %b want 11", {flush_b, upd_b}); else n_pass++;
    tick();
    drive(0, 1, 32'h48, 32'h48, 0, 0);
    n_checks++; if ({flush_b, upd_b} !== 2'b10) $display("FAIL hold_t1: flush/update got %b want 10", {flush_b, upd_b}); else n_pass++;
    tick();
    drive(0, 0, 32'h48, 0, 0, 0);
    n_checks++; if ({flush_b, bc_b, mc_b} !== 5'b1_01_01) $display("FAIL hold_t2: flush/bcnt/mcnt got %b want 10101", {flush_b, bc_b, mc_b}); else n_pass++;
    tick();
    n_checks++; if (flush_b !== 1'b0) $display("FAIL hold_end: got %b want 0", flush_b); else n_pass++;
    n_checks++; if (pred_b !== 1'b1) $display("FAIL hold_nowrite: pred got %b want 1", pred_b); else n_pass++;
  endtask

  task automatic test_alias_bypass();
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 32'h40, 32'h80, 1, 0);
    n_checks++; if (pred_a !== 1'b0) $display("FAIL bypass_old: got %b want 0", pred_a); else n_pass++;
    tick();
    drive(0, 1, 32'h40, 32'h40, 1, 1);
    n_checks++; if (pred_a !== 1'b1) $display("FAIL alias_shared: got %b want 1", pred_a); else n_pass++;
    tick();
    drive(0, 1, 32'h80, 32'h80, 0, 1); tick();
    drive(0, 1, 32'h80, 32'h40, 0, 1);
    n_checks++; if (pred_a !== 1'b1) $display("FAIL alias_dec1: got %b want 1", pred_a); else n_pass++;
    tick();
    drive(0, 0, 32'h80, 0, 0, 0);
    n_checks++; if (pred_a !== 1'b0) $display("FAIL alias_dec2: got %b want 0", pred_a); else n_pass++;
  endtask

  task automatic test_rst_hold_stat();
    drive(1, 0, 0, 0, 0, 0); tick();
    for (int n = 0; n < 5; n++) begin
      drive(0, 1, 32'h4C, 32'h4C, n[0], ~n[0]); tick();
      drive(0, 0, 0, 0, 0, 0); tick(); tick();
    end
    n_checks++; if (mc_b !== 2'd3) $display("FAIL stat_sat_mcnt: got %0d want 3", mc_b); else n_pass++;
    n_checks++; if (bc_b !== 2'd3) $display("FAIL stat_sat_bcnt: got %0d want 3", bc_b); else n_pass++;
    drive(0, 1, 32'h4C, 32'h4C, 1, 0); tick();
    n_checks++; if (flush_b !== 1'b1) $display("FAIL rst_hold_pre: got %b want 1", flush_b); else n_pass++;
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    n_checks++; if ({flush_b, mc_b} !== 3'b000) $display("FAIL rst_hold_end: flush/mcnt got %b want 000", {flush_b, mc_b}); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] pcs [4];
    pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'h1044; pcs[3] = 32'h5C;
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] ip, ep;
      logic b, a, p, r;
      r  = ($urandom_range(0, 59) == 0);
      b  = $urandom_range(0, 2) != 0;
      ip = ($urandom_range(0, 1) == 1) ? pcs[$urandom_range(0, 3)] : $urandom;
      ep = ($urandom_range(0, 1) == 1) ? pcs[$urandom_range(0, 3)] : $urandom;
      a  = $urandom_range(0, 1) == 1;
      p  = $urandom_range(0, 1) == 1;
      drive(r, b, ip, ep, a, p);
      n_checks++;
      if ({pred_a, flush_a, upd_a, bc_a, mc_a} !==
          {m_pred(0), m_flush(0), m_accept(0), 16'(m_bc[0]), 16'(m_mc[0])})
        $display("FAIL rand_a cyc %0d: pred/flush/upd/bc/mc got %b %b %b %0d %0d want %b %b %b %0d %0d",
                 n, pred_a, flush_a, upd_a, bc_a, mc_a,
                 m_pred(0), m_flush(0), m_accept(0), m_bc[0], m_mc[0]);
      else n_pass++;
      n_checks++;
      if ({pred_b, flush_b, upd_b, bc_b, mc_b} !==
          {m_pred(1), m_flush(1), m_accept(1), 2'(m_bc[1]), 2'(m_mc[1])})
        $display("FAIL rand_b cyc %0d: pred/flush/upd/bc/mc got %b %b %b %0d %0d want %b %b %b %0d %0d",
                 n, pred_b, flush_b, upd_b, bc_b, mc_b,
                 m_pred(1), m_flush(1), m_accept(1), m_bc[1], m_mc[1]);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_training();
    test_saturation();
    test_flush_hold();
    test_alias_bypass();
    test_rst_hold_stat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve.md
BRANCH_PREDICT_RESOLVE -- requirements
Module: branch_predict_resolve

Interface
REQ-001 SHALL have parameter PC_W, default 32, program counter width.
REQ-002 SHALL have parameter IDX_W, default 4, pattern history table (PHT) index width; depth 2**IDX_W.
REQ-003 SHALL have parameter CNT_W, default 2, saturating counter width per PHT entry, legal range 2..4.
REQ-004 SHALL have parameter FLUSH_CYC, default 1, flush length in cycles, legal range 1..15.
REQ-005 SHALL have parameter STAT_W, default 16, statistics counter width.
REQ-006 SHALL use one clock and a synchronous active-high reset: ports clk and rst.
REQ-007 SHALL have the following ports, one per line:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- if_pc  input  PC_W  fetch-stage PC to predict
- predict_pcsrc  output  1  predicted taken for if_pc
- branch  input  1  resolving branch valid in execute stage
- ex_pc  input  PC_W  PC of resolving branch
- actual_pcsrc  input  1  resolved taken outcome
- ex_predict_pcsrc  input  1  prediction carried down the pipe with that branch
- flush  output  1  squash younger instructions
- update  output  1  PHT write occurring this cycle
- branch_cnt  output  STAT_W  resolved branches counted
- mispredict_cnt  output  STAT_W  mispredictions counted

Function
REQ-008 SHALL index the PHT by PC bits [IDX_W+1:2] for both if_pc and ex_pc.
REQ-009 SHALL drive predict_pcsrc combinationally as the MSB of the indexed entry, from the value stored before the current edge; no write-to-read bypass.
REQ-010 SHALL treat a resolution as accepted when branch=1 and the flush-hold counter is 0.
REQ-011 SHALL, on an accepted resolution, assert update combinationally in that cycle and write the ex_pc entry at the next edge: actual_pcsrc=1 increments, saturating at 2**CNT_W-1; actual_pcsrc=0 decrements, saturating at 0.
REQ-012 SHALL assert flush combinationally in the accepted cycle when actual_pcsrc XOR ex_predict_pcsrc is 1.
REQ-013 SHALL, on a mispredict, load the hold counter with FLUSH_CYC-1 and keep flush=1 while the hold counter is nonzero, decrementing once per cycle; total flush width is exactly FLUSH_CYC cycles.
REQ-014 SHALL, while the hold counter is nonzero, ignore branch: no PHT write, update=0, no statistics change, no new flush load.
REQ-015 SHALL increment branch_cnt on every accepted resolution, and increment mispredict_cnt on every accepted mispredict, both saturating at 2**STAT_W-1.
REQ-016 SHALL drive flush=0 and update=0 when branch=0 and the hold counter is 0.
REQ-017 SHALL allow same-cycle lookup and update of the same index; predict_pcsrc reflects the old value in that cycle and the new value from the next cycle.

Reset
REQ-018 SHALL, when rst=1 at an edge, set every PHT entry to 2**(CNT_W-1)-1 (weakly not-taken), clear the hold counter, and clear branch_cnt and mispredict_cnt.
REQ-019 SHALL give rst priority over any same-cycle resolution; rst during a flush hold ends the hold, with flush=0 from the next cycle.
REQ-020 SHALL keep flush and update functionally defined (0 unless branch=1) in the reset cycle, with no state change.

Verification
REQ-021 SHALL cover the reset state: after rst, if_pc=0x40 -> predict_pcsrc=0, branch_cnt=0, mispredict_cnt=0.
REQ-022 SHALL cover counter training: ex_pc=0x40, actual_pcsrc=1, accepted twice with ex_predict_pcsrc=0 then 1 -> entry 01->10->11, predict_pcsrc=1 from the cycle after the first write, mispredict_cnt=1, branch_cnt=2.
REQ-023 SHALL cover saturation: five taken resolutions at one index -> entry stays 11; five not-taken -> entry stays 00 with no wrap.
REQ-024 SHALL cover flush hold with FLUSH_CYC=3: mispredict at cycle t -> flush=1 for t..t+2; branch=1 at t+1 -> update=0, counters unchanged, flush ends at t+3.
REQ-025 SHALL cover aliasing and bypass: ex_pc=0x40 and 0x80 with IDX_W=4 hit the same entry (index 0) and both update it; same-cycle if_pc=ex_pc shows the old prediction.
REQ-026 SHALL cover rst mid-hold and statistics saturation: STAT_W=2, four mispredicts -> mispredict_cnt stays 3; rst during hold -> flush=0 next cycle.
